// File: rtl/tpu_feed_pkg.sv
// Shared state type and drain constants for the TPU operand feeder.
package tpu_feed_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } feed_state_t;

  // Must equal the depth of the downstream reg_delay_8L operand line.
  localparam int DRAIN_CYCLES = 8;
  localparam int DRAIN_CNT_W  = $clog2(DRAIN_CYCLES);

endpackage

// File: rtl/feeder_fifo.sv
// Synchronous FIFO with head-of-queue read data and an occupancy count.
module feeder_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push_s, pop_s;

  assign push_s  = push_i && (count_q != (PTR_W+1)'(DEPTH));
  assign pop_s   = pop_i && (count_q != '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_s)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_s) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/tpu_operand_feeder.sv
// Operand feeder ahead of the reg_delay_8L line: FIFO, row drain window, row_done.
// Optional row-length checker enabled by defining FEEDER_ROWLEN_CHECK_EN.
module tpu_operand_feeder
  import tpu_feed_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int FIFO_DEPTH = 8,
  parameter int ROW_LEN    = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [DATA_WIDTH-1:0]       in_data_i,
  input  logic                        in_valid_i,
  input  logic                        in_last_i,
  output logic                        in_ready_o,
  input  logic                        feed_en_i,
  output logic [DATA_WIDTH-1:0]       feed_data_o,
  output logic                        feed_valid_o,
  output logic                        feed_last_o,
  output logic                        row_done_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
  output logic                        row_len_err_o
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  feed_state_t            state_q, state_d;
  logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [DATA_WIDTH-1:0]  feed_data_q, feed_data_d;
  logic                   feed_valid_q, feed_valid_d;
  logic                   feed_last_q, feed_last_d;
  logic                   row_done_q, row_done_d;
  logic [CNT_W-1:0]       count_s;
  logic [DATA_WIDTH:0]    head_s;
  logic                   push_s, pop_s, nonempty_s;

  // in_ready depends only on the registered count, never on this cycle's pop.
  assign nonempty_s = (count_s != '0);
  assign in_ready_o = (count_s < CNT_W'(FIFO_DEPTH));
  assign push_s     = in_valid_i && in_ready_o;
  assign pop_s      = (state_q == FEED) && feed_en_i && nonempty_s;

  feeder_fifo #(.WIDTH(DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (push_s),
    .pop_i     (pop_s),
    .wdata_i   ({in_last_i, in_data_i}),
    .rdata_o   (head_s),
    .count_o   (count_s)
  );

  always_comb begin
    state_d      = state_q;
    drain_cnt_d  = drain_cnt_q;
    row_done_d   = 1'b0;
    feed_data_d  = '0;
    feed_valid_d = 1'b0;
    feed_last_d  = 1'b0;
    if (pop_s) begin
      feed_data_d  = head_s[DATA_WIDTH-1:0];
      feed_valid_d = 1'b1;
      feed_last_d  = head_s[DATA_WIDTH];
    end else begin
      feed_data_d  = '0;
    end
    case (state_q)
      IDLE: begin
        if (nonempty_s) state_d = FEED;
        else            state_d = IDLE;
      end
      FEED: begin
        if (pop_s && head_s[DATA_WIDTH]) begin
          state_d     = DRAIN;
          drain_cnt_d = DRAIN_CNT_W'(DRAIN_CYCLES - 1);
        end else begin
          state_d     = FEED;
        end
      end
      DRAIN: begin
        // Free-running drain: feed_en has no effect here.
        if (drain_cnt_q == '0) begin
          row_done_d = 1'b1;
          state_d    = nonempty_s ? FEED : IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      drain_cnt_q  <= '0;
      feed_data_q  <= '0;
      feed_valid_q <= 1'b0;
      feed_last_q  <= 1'b0;
      row_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_cnt_q  <= drain_cnt_d;
      feed_data_q  <= feed_data_d;
      feed_valid_q <= feed_valid_d;
      feed_last_q  <= feed_last_d;
      row_done_q   <= row_done_d;
    end
  end

  assign feed_data_o  = feed_data_q;
  assign feed_valid_o = feed_valid_q;
  assign feed_last_o  = feed_last_q;
  assign row_done_o   = row_done_q;
  assign busy_o       = nonempty_s || (state_q != IDLE);
  assign fifo_count_o = count_s;

`ifdef FEEDER_ROWLEN_CHECK_EN
  localparam int WC_W = $clog2(ROW_LEN + 2);

  logic [WC_W-1:0] word_cnt_q;
  logic            row_len_err_q;

  // Saturating count so an over-long row cannot wrap back to a legal length.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      word_cnt_q    <= '0;
      row_len_err_q <= 1'b0;
    end else if (pop_s) begin
      if (head_s[DATA_WIDTH]) begin
        word_cnt_q <= '0;
        if ((32'(word_cnt_q) + 32'd1) != 32'(ROW_LEN)) row_len_err_q <= 1'b1;
      end else if (word_cnt_q != '1) begin
        word_cnt_q <= word_cnt_q + 1'b1;
      end
    end
  end

  assign row_len_err_o = row_len_err_q;
`else
  // Constant 0 for any legal ROW_LEN.
  assign row_len_err_o = (ROW_LEN < 1);
`endif

endmodule

// File: tb/tb_tpu_operand_feeder.sv
// Randomised and directed bench for tpu_operand_feeder against a queue/timestamp model.
module tb_tpu_operand_feeder;
  localparam int DW = 18;
  localparam int FD = 8;
  localparam int RL = 16;
  localparam int BIG = 32'h7fff_ffff;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0, in_last = 1'b0, feed_en = 1'b0;
  logic          in_ready, feed_valid, feed_last, row_done, busy, row_len_err;
  logic [DW-1:0] feed_data;
  logic [3:0]    fifo_count;

  tpu_operand_feeder #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .ROW_LEN(RL)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_last_i(in_last), .in_ready_o(in_ready), .feed_en_i(feed_en),
    .feed_data_o(feed_data), .feed_valid_o(feed_valid), .feed_last_o(feed_last),
    .row_done_o(row_done), .busy_o(busy), .fifo_count_o(fifo_count),
    .row_len_err_o(row_len_err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0;

  // Reference model: queue of {last,data} plus row timestamps.
  logic [DW:0]   mq[$];
  logic [DW:0]   stim[$];
  bit            m_idle = 1'b1, m_push = 1'b0, hold_valid = 1'b0;
  int            m_ready_at = 0, m_done_at = -1, m_words = 0;
  logic [DW-1:0] e_data = '0;
  bit            e_valid = 1'b0, e_last = 1'b0, e_done = 1'b0, e_err = 1'b0;
  bit            e_ready = 1'b1, e_busy = 1'b0;
  int            e_count = 0;
  int            t_first_valid, t_last, t_done, t_gap;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_idle = 1'b1; m_ready_at = 0; m_done_at = -1; m_words = 0; m_push = 1'b0;
    e_data = '0; e_valid = 1'b0; e_last = 1'b0; e_done = 1'b0; e_err = 1'b0;
    e_ready = 1'b1; e_busy = 1'b0; e_count = 0;
  endtask

  task automatic model_step();
    int pre;
    bit pop;
    logic [DW:0] w;
    pre    = mq.size();
    m_push = in_valid && (pre < FD);
    pop    = !m_idle && (cyc >= m_ready_at) && feed_en && (pre > 0);
    e_done = (cyc == m_done_at);
    if (e_done) begin
      if (pre > 0) m_ready_at = cyc + 1;
      else         m_idle = 1'b1;
      m_done_at = -1;
    end else if (m_idle && pre > 0) begin
      m_idle = 1'b0;
      m_ready_at = cyc + 1;
    end
    if (pop) begin
      w = mq.pop_front();
      e_data = w[DW-1:0]; e_valid = 1'b1; e_last = w[DW];
      m_words++;
      if (w[DW]) begin
        m_done_at  = cyc + 8;
        m_ready_at = BIG;
`ifdef FEEDER_ROWLEN_CHECK_EN
        if (m_words != RL) e_err = 1'b1;
`endif
        m_words = 0;
      end
    end else begin
      e_data = '0; e_valid = 1'b0; e_last = 1'b0;
    end
    if (m_push) mq.push_back({in_last, in_data});
    e_count = mq.size();
    e_ready = (e_count < FD);
    e_busy  = (e_count > 0) || !m_idle;
    cyc++;
  endtask

  task automatic compare_all();
    check_val("feed_data", 32'(feed_data), 32'(e_data));
    check_val("feed_valid", 32'(feed_valid), 32'(e_valid));
    check_val("feed_last", 32'(feed_last), 32'(e_last));
    check_val("row_done", 32'(row_done), 32'(e_done));
    check_val("in_ready", 32'(in_ready), 32'(e_ready));
    check_val("busy", 32'(busy), 32'(e_busy));
    check_val("fifo_count", 32'(fifo_count), 32'(e_count));
    check_val("row_len_err", 32'(row_len_err), 32'(e_err));
    if (feed_valid && t_first_valid < 0) t_first_valid = cyc - 1;
    if (feed_valid && t_last >= 0 && t_gap < 0 && (cyc - 1) > t_last) t_gap = cyc - 2 - t_last;
    if (feed_last && t_last < 0) t_last = cyc - 1;
    if (row_done && t_done < 0) t_done = cyc - 1;
  endtask

  task automatic clear_track();
    t_first_valid = -1; t_last = -1; t_done = -1; t_gap = -1;
  endtask

  task automatic cycle();
    if (stim.size() > 0 && !hold_valid) begin
      in_valid = 1'b1; in_data = stim[0][DW-1:0]; in_last = stim[0][DW];
    end else begin
      in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    end
    @(posedge clk);
    model_step();
    if (m_push) void'(stim.pop_front());
    @(negedge clk);
    compare_all();
  endtask

  task automatic load_row(input int n, input int base, input bit mark_last);
    for (int i = 0; i < n; i++)
      stim.push_back({(mark_last && i == n - 1), DW'(base + i)});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int start;
    bit seen;
    clear_track();
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    reset_n = 1'b1;

    // Single row of 16 with feed_en held high.
    feed_en = 1'b1;
    clear_track();
    start = cyc;
    load_row(16, 1, 1'b1);
    run(30);
    check_val("latency", 32'(t_first_valid - start), 32'd2);
    check_val("done_after_last", 32'(t_done - t_last), 32'd8);

    // Fill while the array is stalled; two words must wait for space.
    feed_en = 1'b0;
    load_row(10, 32'h100, 1'b1);
    run(12);
    check_val("full_count", 32'(fifo_count), 32'd8);
    check_val("full_ready", 32'(in_ready), 32'd0);
    feed_en = 1'b1;
    run(30);

    // feed_en toggled 1,0,1,0 while feeding.
    load_row(16, 32'h200, 1'b1);
    for (int i = 0; i < 32; i++) begin
      feed_en = (i >= 2 && i < 6) ? ((i % 2) == 0) : 1'b1;
      cycle();
    end

    // Two back-to-back rows.
    clear_track();
    load_row(16, 32'h300, 1'b1);
    load_row(16, 32'h400, 1'b1);
    run(50);
    check_val("row_gap", 32'(t_gap), 32'd8);
    check_val("row1_done", 32'(t_done - t_last), 32'd8);

    // Reset in the middle of a drain window.
    load_row(4, 32'h500, 1'b1);
    load_row(3, 32'h600, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      cycle();
      seen = feed_last;
    end
    check_val("drain_seen", 32'(seen), 32'd1);
    run(4);
    #2 reset_n = 1'b0;
    #1;
    check_val("rst_feed_valid", 32'(feed_valid), 32'd0);
    check_val("rst_row_done", 32'(row_done), 32'd0);
    check_val("rst_count", 32'(fifo_count), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_ready", 32'(in_ready), 32'd1);
    stim.delete();
    model_reset();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    compare_all();
    reset_n = 1'b1;
    run(15);

    // Short row of 15 words.
    load_row(15, 32'h700, 1'b1);
    run(40);

    // Random traffic.
    for (int i = 0; i < 2500; i++) begin
      if (stim.size() < 3 && ($urandom % 2) == 0)
        stim.push_back({(($urandom % 6) == 0), DW'($urandom)});
      hold_valid = (($urandom % 4) == 0);
      feed_en    = (($urandom % 5) != 0);
      cycle();
    end
    hold_valid = 1'b0;
    feed_en = 1'b1;
    stim.push_back({1'b1, DW'(32'h3ffff)});
    run(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tpu_operand_feeder.md
# tpu_operand_feeder

Upstream stage of the 8-stage operand delay line (`reg_delay_8L`) in the TPU datapath. It accepts residue-digit operand words over a valid/ready handshake and buffers them in a small FIFO. It presents one word per cycle, tagged valid, to the free-running delay line. At each row end it inserts a drain window of bubbles and pulses `row_done` on the exact cycle the row's last word reaches the delay-line output.

## Interface
- `DATA_WIDTH`, 18: operand word width; matches the delay line.
- `FIFO_DEPTH`, 8: input buffer depth; power of two, at least 2.
- `ROW_LEN`, 16: expected words per row. Used only by the row-length check.
- `clk  in  1`: single clock, rising edge.
- `reset_n  in  1`: asynchronous, active-low reset.
- `in_data  in  DATA_WIDTH`: operand word.
- `in_valid  in  1`: `in_data`/`in_last` are valid.
- `in_last  in  1`: word is the last of its row.
- `in_ready  out  1`: feeder can accept a word.
- `feed_en  in  1`: array permits new operands this cycle.
- `feed_data  out  DATA_WIDTH`: word to the delay line.
- `feed_valid  out  1`: `feed_data` carries a real word.
- `feed_last  out  1`: `feed_data` is a row's last word.
- `row_done  out  1`: one-cycle pulse; the last word is at the delay-line output.
- `busy  out  1`: FIFO non-empty or state ≠ IDLE.
- `fifo_count  out  $clog2(FIFO_DEPTH)+1`: current FIFO occupancy.
- `row_len_err  out  1`: sticky row-length error flag.

## Operation
- FIFO stores `{in_last, in_data}`.
- Push occurs when `in_valid && in_ready`. `in_ready = (fifo_count < FIFO_DEPTH)` and is registered-state only; there is no combinational path from a pop.
- Pop occurs when state is FEED, `feed_en=1` and `fifo_count>0`.
- A simultaneous push and pop leaves the count unchanged. A push while full cannot occur, because `in_ready=0`.
- States:
  - IDLE: FIFO empty and no row in progress. Goes to FEED when `fifo_count>0`.
  - FEED: pops per the rule above. If the popped word has last=1, go to DRAIN and load `drain_cnt=DRAIN_CYCLES-1`. If the FIFO becomes empty without a last word, stay in FEED.
  - DRAIN: no pops; pushes are still accepted. `drain_cnt` decrements each cycle. At `drain_cnt==0`, assert `row_done` for the next cycle, then go to FEED if `fifo_count>0`, else IDLE.
- Feed outputs are registered:
  - On a pop: `feed_data` = word, `feed_valid=1`, `feed_last` = the word's last flag.
  - Otherwise: `feed_data=0`, `feed_valid=0`, `feed_last=0` (zero bubble).
- `feed_en=0` during DRAIN does not pause the drain, because the delay line is free-running.

## Timing
- Reset values: `feed_data=0`, `feed_valid=0`, `feed_last=0`, `row_done=0`, `busy=0`, `fifo_count=0`, `in_ready=1`, `row_len_err=0`, state IDLE.
- Reset asserted mid-row or mid-drain drops all FIFO contents and any pending `row_done`.
- Input to `feed_data` latency: a word pushed at edge E into an empty FIFO, in IDLE with `feed_en=1`, appears on `feed_data` after edge E+2. E+1 is the IDLE→FEED transition; E+2 is the pop.
- Last word on `feed_data` after edge E0 → `row_done=1` after edge E0+8, which coincides with that word on the delay-line output. No pop occurs between E0+1 and E0+8.
- Throughput is one word per cycle within a row. Row overhead is 8 bubble cycles plus 1 cycle if the FIFO was empty at the end of the drain.
- FIFO pointers wrap modulo `FIFO_DEPTH`.

## Configuration
- `FEEDER_ROWLEN_CHECK_EN` defined:
  - A word counter increments on each pop and clears on a popped last word.
  - If a last word pops with a count of words ≠ `ROW_LEN` (including itself), `row_len_err` sets.
  - `row_len_err` clears only on reset.
- Undefined: the counter is omitted and `row_len_err` is tied to 0.

## Structure
- Package `tpu_feed_pkg` holds:
  - the state enum `feed_state_t` (IDLE, FEED, DRAIN);
  - `localparam DRAIN_CYCLES = 8`, which must equal the delay-line depth.
- Sub-module `feeder_fifo`: a synchronous FIFO with async active-low reset, width `DATA_WIDTH+1`, depth `FIFO_DEPTH`, and a count output.

## Test plan
- Reset, then push 16 words 0x00001..0x00010 with the last on 0x00010, holding `feed_en=1`:
  - `feed_data` shows 1..16 consecutively from edge 2;
  - `row_done` pulses exactly 8 cycles after `feed_last`;
  - `row_len_err=0`.
- Push 10 words while `feed_en=0`:
  - `fifo_count` reaches 8 and `in_ready` drops; words 9 and 10 stall;
  - after `feed_en=1`, all 10 words emerge in order with no loss.
- Toggle `feed_en` 1,0,1,0 during a row: a zero bubble with `feed_valid=0` appears on each low cycle.
- Send two back-to-back rows of 16:
  - 8 bubbles separate them;
  - pushes continue during DRAIN;
  - row 2's first word follows the `row_done` cycle of row 1.
- Assert `reset_n` low at drain cycle 4:
  - all outputs go to reset values immediately;
  - no `row_done` pulse;
  - `fifo_count=0`.
- With `FEEDER_ROWLEN_CHECK_EN` and a 15-word row: `row_len_err=1` after the last pop and stays set.
